// File: rtl/pipe_trace_pkg.sv
// Shared types and helpers for the pipeline trace buffer.
//   trace_state_e : capture FSM encoding (visible on the state port)
//   rec_width     : width of one stored record {stamp, stage words}
//   stage_slice   : extracts one stage word from a flattened stage bus
package pipe_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  // Upper bounds for the generic stage-slice helper.
  localparam int unsigned MAX_IW     = 64;
  localparam int unsigned MAX_STAGES = 8;
  localparam int unsigned MAX_BUS_W  = MAX_IW * MAX_STAGES;

  function automatic int unsigned rec_width(input int unsigned cw,
                                            input int unsigned stages,
                                            input int unsigned iw);
    return cw + stages * iw;
  endfunction

  // Returns stage s of a bus packed as s*iw +: iw; caller truncates to iw.
  function automatic logic [MAX_IW-1:0] stage_slice(input logic [MAX_BUS_W-1:0] bus,
                                                    input int unsigned        s,
                                                    input int unsigned        iw);
    logic [MAX_BUS_W-1:0] sh;
    sh = bus >> (s * iw);
    return MAX_IW'(sh);
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Record storage for the trace buffer.
//   clk         : write clock
//   we/waddr/wdata : synchronous write port
//   raddr/rdata : asynchronous read port (show-ahead head record)
// Contents are intentionally not reset.
module trace_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 192
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_trace_buffer.sv
// Pipeline trace buffer: records per-stage instruction words with a cycle
// stamp into a ring buffer, stops a programmable number of samples after a
// masked-compare trigger, then drains oldest-first over valid/ready.
//   clk, rst_n            : clock, async active-low reset
//   en, instr_bus         : sample qualifier and tapped stage words
//   arm                   : clear buffer and restart capture
//   trig_stage/value/mask : trigger compare setup (latched on arm)
//   post_len              : samples to keep after the trigger sample
//   rd_valid/ready/cycle/instr : drain port (show-ahead)
//   state, fill, wrapped  : status
module pipe_trace_buffer
  import pipe_trace_pkg::*;
#(
  parameter int unsigned STAGES = 5,
  parameter int unsigned IW     = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CW     = 32,
  parameter int unsigned SW     = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [STAGES*IW-1:0]     instr_bus,
  input  logic                     arm,
  input  logic [SW-1:0]            trig_stage,
  input  logic [IW-1:0]            trig_value,
  input  logic [IW-1:0]            trig_mask,
  input  logic [$clog2(DEPTH)-1:0] post_len,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [CW-1:0]            rd_cycle,
  output logic [STAGES*IW-1:0]     rd_instr,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     wrapped
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = STAGES * IW;
  localparam int unsigned RW = rec_width(CW, STAGES, IW);

  trace_state_e   state_q,   state_d;
  logic [CW-1:0]  cyc_q,     cyc_d;
  logic [AW-1:0]  wr_ptr_q,  wr_ptr_d;
  logic [AW:0]    fill_q,    fill_d;
  logic           wrapped_q, wrapped_d;
  logic [AW-1:0]  rem_q,     rem_d;
  logic [SW-1:0]  tstage_q,  tstage_d;
  logic [IW-1:0]  tval_q,    tval_d;
  logic [IW-1:0]  tmask_q,   tmask_d;
  logic [AW-1:0]  post_q,    post_d;

  logic           we_c;
  logic [IW-1:0]  trig_word_c;
  logic           trig_hit_c;
  logic [AW-1:0]  head_c;
  logic [RW-1:0]  rdata_c;
  logic           rd_valid_c;

  // Trigger compare on the latched stage/value/mask.
  always_comb begin
    trig_word_c = IW'(stage_slice(MAX_BUS_W'(instr_bus), 32'(tstage_q), IW));
    trig_hit_c  = en && (32'(tstage_q) < STAGES) &&
                  (((trig_word_c ^ tval_q) & tmask_q) == '0);
  end

  // Next-state, counters and write enable.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q + CW'(1);
    wr_ptr_d  = wr_ptr_q;
    fill_d    = fill_q;
    wrapped_d = wrapped_q;
    rem_d     = rem_q;
    tstage_d  = tstage_q;
    tval_d    = tval_q;
    tmask_d   = tmask_q;
    post_d    = post_q;
    we_c      = 1'b0;

    if (arm) begin
      state_d   = ST_ARMED;
      wr_ptr_d  = '0;
      fill_d    = '0;
      wrapped_d = 1'b0;
      tstage_d  = trig_stage;
      tval_d    = trig_value;
      tmask_d   = trig_mask;
      post_d    = post_len;
    end else begin
      unique case (state_q)
        ST_ARMED, ST_POST: begin
          if (en) begin
            we_c     = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (fill_q == (AW+1)'(DEPTH)) begin
              wrapped_d = 1'b1;
            end else begin
              fill_d = fill_q + (AW+1)'(1);
            end
            if (state_q == ST_ARMED) begin
              if (trig_hit_c) begin
                if (post_q == '0) begin
                  state_d = ST_DONE;
                end else begin
                  state_d = ST_POST;
                  // Keep at least the trigger record inside the ring.
                  rem_d   = (32'(post_q) > DEPTH - 1) ? AW'(DEPTH - 1) : post_q;
                end
              end
            end else begin
              rem_d = rem_q - AW'(1);
              if (rem_q == AW'(1)) begin
                state_d = ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          if (fill_q == '0) begin
            state_d = ST_IDLE;
          end else if (rd_ready) begin
            fill_d = fill_q - (AW+1)'(1);
            if (fill_q == (AW+1)'(1)) begin
              state_d = ST_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cyc_q     <= '0;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      wrapped_q <= 1'b0;
      rem_q     <= '0;
      tstage_q  <= '0;
      tval_q    <= '0;
      tmask_q   <= '0;
      post_q    <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      wr_ptr_q  <= wr_ptr_d;
      fill_q    <= fill_d;
      wrapped_q <= wrapped_d;
      rem_q     <= rem_d;
      tstage_q  <= tstage_d;
      tval_q    <= tval_d;
      tmask_q   <= tmask_d;
      post_q    <= post_d;
    end
  end

  // Oldest unread entry; fill==DEPTH wraps naturally back to wr_ptr.
  assign head_c = wr_ptr_q - AW'(fill_q);

  trace_ram #(
    .DEPTH (DEPTH),
    .W     (RW)
  ) u_ram (
    .clk   (clk),
    .we    (we_c),
    .waddr (wr_ptr_q),
    .wdata ({cyc_q, instr_bus}),
    .raddr (head_c),
    .rdata (rdata_c)
  );

  // Drain port: data forced to zero when nothing valid (RAM is not reset).
  assign rd_valid_c = (state_q == ST_DONE) && (fill_q != '0);
  assign rd_valid   = rd_valid_c;
  assign rd_cycle   = rd_valid_c ? rdata_c[RW-1 -: CW] : '0;
  assign rd_instr   = rd_valid_c ? rdata_c[BW-1:0]     : '0;

  assign state   = 2'(state_q);
  assign fill    = fill_q;
  assign wrapped = wrapped_q;

endmodule
